// File: rtl/sqrt_pkg.sv
// Shared helpers for the pipelined square root: width/latency derivation and defaults.
package sqrt_pkg;

  localparam int unsigned IN_W_DEF      = 16;
  localparam int unsigned REG_EVERY_DEF = 2;
  localparam int unsigned TAG_W_DEF     = 4;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  function automatic int unsigned out_w(input int unsigned in_w);
    return in_w / 2;
  endfunction

  function automatic int unsigned rem_w(input int unsigned ow);
    return ow + 2;
  endfunction

  function automatic int unsigned nreg(input int unsigned in_w, input int unsigned reg_every);
    return ceil_div(out_w(in_w), reg_every);
  endfunction

  // Index of the last recurrence step feeding pipeline register k.
  function automatic int unsigned last_step(input int unsigned k, input int unsigned reg_every,
                                            input int unsigned ow);
    return ((k + 1) * reg_every > ow) ? ow - 1 : (k + 1) * reg_every - 1;
  endfunction

endpackage

// File: rtl/sqrt_pipe_param_if.sv
// Operand/result handshake bundle for sqrt_pipe_param; rem_o exists only with SQRT_REM_EN.
interface sqrt_pipe_param_if
  import sqrt_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned TAG_W = TAG_W_DEF
) ();

  localparam int unsigned OUT_W = out_w(IN_W);

  logic             in_valid_i;
  logic             in_ready_o;
  logic [IN_W-1:0]  in_data_i;
  logic [TAG_W-1:0] in_tag_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [OUT_W-1:0] root_o;
  logic [TAG_W-1:0] tag_o;
`ifdef SQRT_REM_EN
  logic [OUT_W:0]   rem_o;
`endif

  modport slave (
    input  in_valid_i, in_data_i, in_tag_i, out_ready_i,
`ifdef SQRT_REM_EN
    output rem_o,
`endif
    output in_ready_o, out_valid_o, root_o, tag_o
  );

  modport master (
    output in_valid_i, in_data_i, in_tag_i, out_ready_i,
`ifdef SQRT_REM_EN
    input  rem_o,
`endif
    input  in_ready_o, out_valid_o, root_o, tag_o
  );

endinterface

// File: rtl/sqrt_step.sv
// One restoring square-root recurrence step: resolves one root bit from the next radicand pair.
module sqrt_step
  import sqrt_pkg::*;
#(
  parameter int unsigned OUT_W = out_w(IN_W_DEF)
) (
  input  logic [rem_w(OUT_W)-1:0] rem_i,
  input  logic [OUT_W-1:0]        root_i,
  input  logic [1:0]              pair_i,
  output logic [rem_w(OUT_W)-1:0] rem_o,
  output logic [OUT_W-1:0]        root_o
);

  localparam int unsigned REM_W = rem_w(OUT_W);
  localparam int unsigned ACC_W = REM_W + 2;

  logic [ACC_W-1:0] acc_c;
  logic [ACC_W-1:0] sub_c;
  logic [ACC_W-1:0] diff_c;

  // Trial subtract of {root,01}; keep the difference only if it did not go negative.
  always_comb begin
    acc_c  = {rem_i, pair_i};
    sub_c  = ACC_W'({root_i, 2'b01});
    diff_c = acc_c - sub_c;
    if (acc_c >= sub_c) begin
      rem_o  = REM_W'(diff_c);
      root_o = {root_i[OUT_W-2:0], 1'b1};
    end else begin
      rem_o  = REM_W'(acc_c);
      root_o = {root_i[OUT_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/sqrt_pipe_param.sv
// Fully pipelined floor(sqrt(x)) with valid/ready backpressure and tag pass-through.
// Define SQRT_REM_EN to expose the final remainder on rem_o.
module sqrt_pipe_param
  import sqrt_pkg::*;
#(
  parameter int unsigned IN_W      = IN_W_DEF,
  parameter int unsigned REG_EVERY = REG_EVERY_DEF,
  parameter int unsigned TAG_W     = TAG_W_DEF
) (
  input logic              clk,
  input logic              rst_n,
  sqrt_pipe_param_if.slave bus
);

  localparam int unsigned OUT_W = out_w(IN_W);
  localparam int unsigned REM_W = rem_w(OUT_W);
  localparam int unsigned NREG  = nreg(IN_W, REG_EVERY);

  if (IN_W % 2 != 0 || IN_W < 4) begin : g_chk_in_w
    $error("sqrt_pipe_param: IN_W must be even and >= 4");
  end
  if (REG_EVERY < 1 || REG_EVERY > OUT_W) begin : g_chk_reg_every
    $error("sqrt_pipe_param: REG_EVERY must be within 1..OUT_W");
  end
  if (TAG_W < 1) begin : g_chk_tag_w
    $error("sqrt_pipe_param: TAG_W must be >= 1");
  end

  typedef struct packed {
    logic             valid;
    logic [REM_W-1:0] rem;
    logic [OUT_W-1:0] root;
    logic [IN_W-1:0]  rad;
    logic [TAG_W-1:0] tag;
  } stage_t;

  stage_t stage_q [NREG];
  stage_t stage_d [NREG];
  logic   adv_c;
  logic   accept_c;
  logic   unused_c;

  // Single global advance: the whole pipe moves unless the output is held.
  assign adv_c          = ~stage_q[NREG-1].valid | bus.out_ready_i;
  assign bus.in_ready_o = rst_n & adv_c;
  assign accept_c       = bus.in_valid_i & bus.in_ready_o;

  for (genvar j = 0; j < OUT_W; j++) begin : g_step
    logic [REM_W-1:0] rem_s;
    logic [REM_W-1:0] rem_n;
    logic [OUT_W-1:0] root_s;
    logic [OUT_W-1:0] root_n;
    logic [IN_W-1:0]  rad_s;
    logic [IN_W-1:0]  rad_n;

    if (j == 0) begin : g_src_in
      assign rem_s  = '0;
      assign root_s = '0;
      assign rad_s  = bus.in_data_i;
    end else if (j % REG_EVERY == 0) begin : g_src_reg
      assign rem_s  = stage_q[j/REG_EVERY-1].rem;
      assign root_s = stage_q[j/REG_EVERY-1].root;
      assign rad_s  = stage_q[j/REG_EVERY-1].rad;
    end else begin : g_src_comb
      assign rem_s  = g_step[j-1].rem_n;
      assign root_s = g_step[j-1].root_n;
      assign rad_s  = g_step[j-1].rad_n;
    end

    // Consumed pair is shifted out so the next step always reads the top two bits.
    assign rad_n = rad_s << 2;

    sqrt_step #(.OUT_W(OUT_W)) u_step (
      .rem_i  (rem_s),
      .root_i (root_s),
      .pair_i (rad_s[IN_W-1 -: 2]),
      .rem_o  (rem_n),
      .root_o (root_n)
    );
  end

  for (genvar k = 0; k < NREG; k++) begin : g_stage
    localparam int unsigned JL = last_step(k, REG_EVERY, OUT_W);
    logic             valid_s;
    logic [TAG_W-1:0] tag_s;

    if (k == 0) begin : g_head
      assign valid_s = accept_c;
      assign tag_s   = bus.in_tag_i;
    end else begin : g_body
      assign valid_s = stage_q[k-1].valid;
      assign tag_s   = stage_q[k-1].tag;
    end

    if (k == NREG - 1) begin : g_tail
`ifdef SQRT_REM_EN
      assign stage_d[k] = '{valid: valid_s, rem: g_step[JL].rem_n, root: g_step[JL].root_n,
                            rad: '0, tag: tag_s};
`else
      assign stage_d[k] = '{valid: valid_s, rem: '0, root: g_step[JL].root_n,
                            rad: '0, tag: tag_s};
`endif
    end else begin : g_mid
      assign stage_d[k] = '{valid: valid_s, rem: g_step[JL].rem_n, root: g_step[JL].root_n,
                            rad: g_step[JL].rad_n, tag: tag_s};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NREG; k++) stage_q[k] <= '0;
    end else if (adv_c) begin
      for (int unsigned k = 0; k < NREG; k++) stage_q[k] <= stage_d[k];
    end
  end

  assign bus.out_valid_o = stage_q[NREG-1].valid;
  assign bus.root_o      = stage_q[NREG-1].root;
  assign bus.tag_o       = stage_q[NREG-1].tag;
`ifdef SQRT_REM_EN
  assign bus.rem_o       = stage_q[NREG-1].rem[OUT_W:0];
`endif

  assign unused_c = ^{stage_q[NREG-1].rad, stage_q[NREG-1].rem, g_step[OUT_W-1].rad_n};

endmodule
